// File: rtl/multicycle_adder_pkg.sv
// Shared definitions for the multi-cycle adder: FSM encoding and the
// width/chunk legality check used at elaboration.
package multicycle_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic bit chunk_fits(input int width, input int chunk);
    return (chunk >= 1) && (width % chunk == 0);
  endfunction

endpackage

// File: rtl/multicycle_adder_csa.sv
// CHUNK-bit conditional-sum adder: both carry-in outcomes are formed in
// parallel and the incoming carry selects between them.
module CSA #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] sum0;
  logic [W:0] sum1;

  assign sum0    = {1'b0, a} + {1'b0, b};
  assign sum1    = sum0 + {{W{1'b0}}, 1'b1};
  assign {co, s} = ci ? sum1 : sum0;

endmodule

// File: rtl/multicycle_adder.sv
// Sequential WIDTH-bit adder/subtractor reusing one CHUNK-bit CSA across
// WIDTH/CHUNK cycles, with start/busy/done handshake and registered flags.
module multicycle_adder
  import multicycle_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]    LAST = IW'(N - 1);
  localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}});

  if (!chunk_fits(WIDTH, CHUNK)) begin : g_bad_chunk
    $error("multicycle_adder: WIDTH must be a nonzero multiple of CHUNK");
  end

  state_t            state;
  state_t            state_next;
  logic [IW-1:0]     idx;
  logic              carry;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic [WIDTH-1:0]  work;
  logic [WIDTH-1:0]  work_next;
  logic [31:0]       base;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK-1:0]  chunk_s;
  logic              chunk_co;

  // Shifts rather than variable part-selects keep the slice logic width-clean.
  always_comb begin
    base      = 32'(idx) * 32'(CHUNK);
    a_chunk   = CHUNK'(a_r >> base);
    b_chunk   = CHUNK'(b_r >> base);
    work_next = (work & ~(MASK << base)) | (WIDTH'(chunk_s) << base);
  end

  CSA #(.W(CHUNK)) u_csa (
    .a  (a_chunk),
    .b  (b_chunk),
    .ci (carry),
    .s  (chunk_s),
    .co (chunk_co)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (idx == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      work  <= '0;
      sum   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? ~ci : ci;
            idx   <= '0;
          end
        end
        RUN: begin
          work  <= work_next;
          carry <= chunk_co;
          idx   <= idx + 1'b1;
          // Outputs take the completed result, including the final chunk.
          if (idx == LAST) begin
            sum <= work_next;
            co  <= chunk_co;
            ovf <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (work_next[WIDTH-1] != a_r[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
